any1_bus_responder: RTL and testbench
=====================================

Name: any1_bus_responder

Overview:
- Wishbone-style memory responder (slave) for the any1 core's bus master port (cyc/stb/we/sel/adr/dat plus reservation signals sr/cr/rb).
- Backs a fixed address window with a byte-enabled on-chip RAM.
- Inserts programmable wait states and tracks one load-reserve/store-conditional reservation so the core's rb input reports store-conditional success.

Parameters:
- AWID, 32, address width.
- DWID, 64, data width (CPU_B64 build); SELW = DWID/8.
- DEPTH, 4096, RAM depth in DWID words; ABITS = $clog2(DEPTH)+$clog2(SELW).
- BASE, 32'h0000_0000, window base; must be aligned to 2**ABITS.
- WAIT_STATES, 1, extra cycles before ack (0..15).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cyc_i  in  1  bus cycle valid
- stb_i  in  1  strobe
- we_i  in  1  write enable
- sel_i  in  SELW  byte lanes
- adr_i  in  AWID  byte address
- dat_i  in  DWID  write data
- sr_i  in  1  set reservation (load-reserve read)
- cr_i  in  1  conditional write (store-conditional)
- ack_o  out  1  transfer acknowledge
- dat_o  out  DWID  read data
- rb_o  out  1  store-conditional result
- err_o  out  1  error (ANY1_BUSRSP_ERR_EN only; tied 0 otherwise)

Behaviour:
- Interface: one clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset values: ack_o=0, dat_o=0, rb_o=0, err_o=0, resv_valid=0, resv_adr=0, state=IDLE, wait counter=0. RAM contents are not reset.
- cs = cyc_i & stb_i & (adr_i[AWID-1:ABITS]==BASE[AWID-1:ABITS]). Word index = adr_i[ABITS-1:$clog2(SELW)].
- FSM states: IDLE, WAIT, ACK, RELEASE.
  - IDLE: on cs, latch we/sel/adr/dat/sr/cr and load wcnt=WAIT_STATES. Go to WAIT if WAIT_STATES>0, else go to ACK.
  - WAIT: decrement wcnt; go to ACK when wcnt==1.
  - ACK: ack_o=1 for exactly one cycle. Write commits to RAM in this cycle; read dat_o is valid in this cycle. Then go to RELEASE.
  - RELEASE: hold until stb_i==0, then return to IDLE. Back-to-back requests need one cycle with stb low.
- Latency: request seen in cycle T gives ack_o in cycle T+1+WAIT_STATES.
- dat_o is 0 outside ACK cycles and on writes.
- Read path: registered RAM read is issued on entry to the last pre-ack cycle. With WAIT_STATES=0 the read is issued in IDLE.
- Abort: if cyc_i drops in WAIT, go to IDLE. No ack, no write, reservation unchanged.
- Out-of-window accesses are ignored (no ack). The bus timeout belongs to the master.
- Reservation rules:
  - Read with sr_i=1: resv_valid=1, resv_adr = word index.
  - Write with cr_i=1: the write commits only if resv_valid and resv_adr==word index. rb_o=1 with ack on success, else rb_o=0 and the RAM is unchanged. resv_valid clears in both cases.
  - Normal write to the reserved word: clears resv_valid. rb_o=0.
  - rb_o=0 in all non-ack cycles and for all non-cr transfers.
  - Simultaneous sr_i & cr_i: treated as cr write (sr ignored); on reads cr_i is ignored.
- Reset mid-transfer: immediate return to IDLE with all outputs at reset values.

Optional Feature:
- Macro: ANY1_BUSRSP_ERR_EN.
- Enabled: an in-window access with sel_i==0, or a cr_i write whose sel_i is not all-ones, gets err_o=1 instead of ack_o. Same timing, no RAM or reservation change, and the reservation is also cleared for the bad cr.
- Disabled: err_o tied 0. Such accesses ack normally; a write with sel_i==0 changes nothing.

Decomposition:
- Package any1_busrsp_pkg holds the state enum (IDLE, WAIT, ACK, RELEASE) and the width localparams (SELW, ABITS).
- One sub-module, any1_busrsp_ram: single-port RAM with byte-lane write enables, registered read, DEPTH x DWID, infers block RAM.

Test Plan:
- Write then read, WAIT_STATES=1: write adr 32'h100, dat 64'hDEADBEEF_01234567, sel 8'hFF -> ack at T+2. Then read 32'h100 -> dat_o=64'hDEADBEEF_01234567 with ack.
- Byte lanes: preload 0, write sel 8'h0C, dat 64'h0000_0000_AABB_CCDD -> read returns 64'h0000_0000_AABB_0000.
- LR/SC success and failure:
  - Read 32'h200 with sr_i=1, then cr write 64'h5 to 32'h200 -> rb_o=1, word = 5.
  - A second cr write 64'h6 -> rb_o=0, word stays 5.
- Reservation kill: sr read at 32'h300, plain write 32'h300 = 64'h1, cr write 32'h300 = 64'h2 -> rb_o=0, word = 1.
- Abort and reset: WAIT_STATES=3, drop cyc_i in the second wait cycle -> no ack, no write. Assert rst_ni low during WAIT -> ack_o, dat_o, rb_o = 0 at once and the FSM returns to IDLE.
- Window and error: access at BASE+2**ABITS -> no ack for 20 cycles. With ANY1_BUSRSP_ERR_EN, in-window sel_i=8'h00 -> err_o=1, ack_o=0.

Source files
------------

// File: rtl/any1_busrsp_pkg.sv
// Shared types and width helpers for the any1 bus responder.
// The CPU_B64 build widths are the defaults; helpers derive widths for other builds.
package any1_busrsp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam int DWID_DEF  = 64;
    localparam int DEPTH_DEF = 4096;
    localparam int SELW      = DWID_DEF / 8;
    localparam int ABITS     = $clog2(DEPTH_DEF) + $clog2(SELW);
    localparam int WCNT_W    = 4;

    function automatic int calc_selw(input int dwid);
        return dwid / 8;
    endfunction

    function automatic int calc_abits(input int depth, input int dwid);
        return $clog2(depth) + $clog2(dwid / 8);
    endfunction

endpackage

// File: rtl/any1_busrsp_ram.sv
// Single-port DEPTH x DWID RAM with byte-lane write enables and a registered
// read port, written in the form block-RAM inference expects.
module any1_busrsp_ram
    import any1_busrsp_pkg::*;
#(
    parameter int DWID  = DWID_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic [DWID/8-1:0]        be_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DWID-1:0]          wdata_i,
    output logic [DWID-1:0]          rdata_o
);

    localparam int SW = calc_selw(DWID);

    logic [DWID-1:0] mem [DEPTH];
    logic [DWID-1:0] rdata_q;

    // NOTE: the array has no reset branch; a reset would force it into fabric
    // flops instead of block RAM, and nothing relies on its power-up contents.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < SW; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/any1_bus_responder.sv
// Wishbone-style RAM responder for the any1 bus master with wait states and an
// LR/SC reservation. Define ANY1_BUSRSP_ERR_EN to answer malformed accesses with err_o.
module any1_bus_responder
    import any1_busrsp_pkg::*;
#(
    parameter int              AWID        = 32,
    parameter int              DWID        = DWID_DEF,
    parameter int              DEPTH       = DEPTH_DEF,
    parameter logic [AWID-1:0] BASE        = '0,
    parameter int              WAIT_STATES = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [DWID/8-1:0] sel_i,
    input  logic [AWID-1:0]   adr_i,
    input  logic [DWID-1:0]   dat_i,
    input  logic              sr_i,
    input  logic              cr_i,
    output logic              ack_o,
    output logic [DWID-1:0]   dat_o,
    output logic              rb_o,
    output logic              err_o
);

    localparam int SW  = calc_selw(DWID);
    localparam int AB  = calc_abits(DEPTH, DWID);
    localparam int LSB = $clog2(SW);
    localparam int IW  = AB - LSB;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                we_q, we_d;
    logic [SW-1:0]       sel_q, sel_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DWID-1:0]     dat_q, dat_d;
    logic                sr_q, sr_d;
    logic                cr_q, cr_d;
    logic                bad_q, bad_d;
    logic                resv_valid_q, resv_valid_d;
    logic [IW-1:0]       resv_adr_q, resv_adr_d;

    logic                cs;
    logic [IW-1:0]       req_idx;
    logic                bad_req;
    logic                sc_ok;
    logic                ram_en;
    logic [SW-1:0]       ram_be;
    logic [IW-1:0]       ram_addr;
    logic [DWID-1:0]     ram_rdata;

    // Byte-offset bits never select anything: lanes are chosen by sel_i.
    logic unused_adr_bits;
    assign unused_adr_bits = ^adr_i[LSB-1:0];

    assign cs      = cyc_i & stb_i & (adr_i[AWID-1:AB] == BASE[AWID-1:AB]);
    assign req_idx = adr_i[AB-1:LSB];
    assign sc_ok   = resv_valid_q & (resv_adr_q == idx_q);

`ifdef ANY1_BUSRSP_ERR_EN
    // No lanes at all, or a partial store-conditional, is answered with err_o.
    assign bad_req = (sel_i == '0) | (we_i & cr_i & ~(&sel_i));
`else
    assign bad_req = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        we_d         = we_q;
        sel_d        = sel_q;
        idx_d        = idx_q;
        dat_d        = dat_q;
        sr_d         = sr_q;
        cr_d         = cr_q;
        bad_d        = bad_q;
        resv_valid_d = resv_valid_q;
        resv_adr_d   = resv_adr_q;
        ram_en       = 1'b0;
        ram_be       = '0;
        ram_addr     = idx_q;
        ack_o        = 1'b0;
        err_o        = 1'b0;
        rb_o         = 1'b0;
        dat_o        = '0;

        case (state_q)
            IDLE: begin
                ram_addr = req_idx;
                if (cs) begin
                    we_d   = we_i;
                    sel_d  = sel_i;
                    idx_d  = req_idx;
                    dat_d  = dat_i;
                    sr_d   = sr_i;
                    cr_d   = cr_i;
                    bad_d  = bad_req;
                    wcnt_d = WCNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d = ACK;
                        ram_en  = ~we_i;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                if (!cyc_i) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                    if (wcnt_q == WCNT_W'(1)) begin
                        state_d = ACK;
                        ram_en  = ~we_q;
                    end
                end
            end

            ACK: begin
                state_d = RELEASE;
                wcnt_d  = '0;
                if (bad_q) begin
                    err_o = 1'b1;
                    if (we_q && cr_q) begin
                        resv_valid_d = 1'b0;
                    end
                end else begin
                    ack_o = 1'b1;
                    if (we_q) begin
                        if (cr_q) begin
                            // Store-conditional: commit only against a live matching reservation.
                            rb_o         = sc_ok;
                            resv_valid_d = 1'b0;
                            if (sc_ok) begin
                                ram_en = 1'b1;
                                ram_be = sel_q;
                            end
                        end else begin
                            ram_en = 1'b1;
                            ram_be = sel_q;
                            if (sc_ok && (sel_q != '0)) begin
                                resv_valid_d = 1'b0;
                            end
                        end
                    end else begin
                        dat_o = ram_rdata;
                        if (sr_q) begin
                            resv_valid_d = 1'b1;
                            resv_adr_d   = idx_q;
                        end
                    end
                end
            end

            RELEASE: begin
                if (!stb_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values computed before this edge regardless of block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            idx_q        <= '0;
            dat_q        <= '0;
            sr_q         <= 1'b0;
            cr_q         <= 1'b0;
            bad_q        <= 1'b0;
            resv_valid_q <= 1'b0;
            resv_adr_q   <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            idx_q        <= idx_d;
            dat_q        <= dat_d;
            sr_q         <= sr_d;
            cr_q         <= cr_d;
            bad_q        <= bad_d;
            resv_valid_q <= resv_valid_d;
            resv_adr_q   <= resv_adr_d;
        end
    end

    any1_busrsp_ram #(
        .DWID  (DWID),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .be_i    (ram_be),
        .addr_i  (ram_addr),
        .wdata_i (dat_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_any1_bus_responder.sv
// Directed bench for any1_bus_responder: two instances (1 and 3 wait states),
// expected responses queued at issue time and compared when ack/err arrives.
module tb_any1_bus_responder;

    localparam int W0 = 1;
    localparam int W1 = 3;

`ifdef ANY1_BUSRSP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [63:0] dat;
        logic        rb;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc  [2];
    logic        stb  [2];
    logic        we   [2];
    logic        sr   [2];
    logic        cr   [2];
    logic [7:0]  sel  [2];
    logic [31:0] adr  [2];
    logic [63:0] din  [2];
    logic [63:0] dout [2];
    logic        ack  [2];
    logic        rb   [2];
    logic        err  [2];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    any1_bus_responder #(.WAIT_STATES(W0)) u_dut0 (
        .clk_i (clk), .rst_ni (rst_n),
        .cyc_i (cyc[0]), .stb_i (stb[0]), .we_i (we[0]), .sel_i (sel[0]),
        .adr_i (adr[0]), .dat_i (din[0]), .sr_i (sr[0]), .cr_i (cr[0]),
        .ack_o (ack[0]), .dat_o (dout[0]), .rb_o (rb[0]), .err_o (err[0])
    );

    any1_bus_responder #(.WAIT_STATES(W1)) u_dut1 (
        .clk_i (clk), .rst_ni (rst_n),
        .cyc_i (cyc[1]), .stb_i (stb[1]), .we_i (we[1]), .sel_i (sel[1]),
        .adr_i (adr[1]), .dat_i (din[1]), .sr_i (sr[1]), .cr_i (cr[1]),
        .ack_o (ack[1]), .dat_o (dout[1]), .rb_o (rb[1]), .err_o (err[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %016h expected %016h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle_bus(input int d);
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sr[d] = 1'b0; cr[d] = 1'b0;
        sel[d] = '0;   adr[d] = '0;   din[d] = '0;
    endtask

    // One complete transfer: queue the expectation, drive, wait (bounded) for
    // ack/err, compare, then give the bus the idle cycles the handshake needs.
    task automatic xfer(input int d, input string tag, input bit w, input logic [7:0] s,
                        input logic [31:0] a, input logic [63:0] wd, input bit srr, input bit crr,
                        input logic [63:0] edat, input bit erb, input bit eerr);
        exp_t e;
        int   lat;
        bit   got;
        e.tag = tag; e.dat = edat; e.rb = erb; e.err = eerr;
        e.lat = 1 + ((d == 0) ? W0 : W1);
        sb.push_back(e);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s;
        adr[d] = a;    din[d] = wd;   sr[d] = srr; cr[d] = crr;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            got = ack[d] | err[d];
        end
        e = sb.pop_front();
        check_bit($sformatf("%s_resp", e.tag), got, 1'b1);
        if (got) begin
            check($sformatf("%s_lat", e.tag), 64'(lat), 64'(e.lat));
            check_bit($sformatf("%s_ack", e.tag), ack[d], ~e.err);
            check_bit($sformatf("%s_err", e.tag), err[d], e.err);
            check($sformatf("%s_dat", e.tag), dout[d], e.dat);
            check_bit($sformatf("%s_rb", e.tag), rb[d], e.rb);
        end
        idle_bus(d);
        @(negedge clk);
        check_bit($sformatf("%s_ack_once", e.tag), ack[d] | err[d], 1'b0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag, input int d);
        check_bit($sformatf("%s_ack", tag), ack[d], 1'b0);
        check($sformatf("%s_dat", tag), dout[d], 64'h0);
        check_bit($sformatf("%s_rb", tag), rb[d], 1'b0);
        check_bit($sformatf("%s_err", tag), err[d], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acks;
        bit got;
        int n;

        rst_n = 1'b1;
        idle_bus(0);
        idle_bus(1);
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0", 0);
        check_reset_outputs("rst1", 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read, one wait state.
        xfer(0, "wr100", 1, 8'hFF, 32'h100, 64'hDEADBEEF_01234567, 0, 0, 64'h0, 0, 0);
        xfer(0, "rd100", 0, 8'hFF, 32'h100, 64'h0, 0, 0, 64'hDEADBEEF_01234567, 0, 0);

        // Byte lanes 2 and 3 only.
        xfer(0, "pre180", 1, 8'hFF, 32'h180, 64'h0, 0, 0, 64'h0, 0, 0);
        xfer(0, "wr180", 1, 8'h0C, 32'h180, 64'h0000_0000_AABB_CCDD, 0, 0, 64'h0, 0, 0);
        xfer(0, "rd180", 0, 8'hFF, 32'h180, 64'h0, 0, 0, 64'h0000_0000_AABB_0000, 0, 0);

        // Write with no lanes leaves the word untouched.
        xfer(0, "wr100_sel0", 1, 8'h00, 32'h100, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'h0, 0, ERR_EN);
        xfer(0, "rd100_after", 0, 8'hFF, 32'h100, 64'h0, 0, 0, 64'hDEADBEEF_01234567, 0, 0);

        // LR/SC success then failure.
        xfer(0, "pre200", 1, 8'hFF, 32'h200, 64'h0, 0, 0, 64'h0, 0, 0);
        xfer(0, "lr200", 0, 8'hFF, 32'h200, 64'h0, 1, 0, 64'h0, 0, 0);
        xfer(0, "sc200_ok", 1, 8'hFF, 32'h200, 64'h5, 0, 1, 64'h0, 1, 0);
        xfer(0, "rd200_a", 0, 8'hFF, 32'h200, 64'h0, 0, 0, 64'h5, 0, 0);
        xfer(0, "sc200_bad", 1, 8'hFF, 32'h200, 64'h6, 0, 1, 64'h0, 0, 0);
        xfer(0, "rd200_b", 0, 8'hFF, 32'h200, 64'h0, 0, 0, 64'h5, 0, 0);

        // A plain write to the reserved word kills the reservation.
        xfer(0, "pre300", 1, 8'hFF, 32'h300, 64'h0, 0, 0, 64'h0, 0, 0);
        xfer(0, "lr300", 0, 8'hFF, 32'h300, 64'h0, 1, 0, 64'h0, 0, 0);
        xfer(0, "wr300", 1, 8'hFF, 32'h300, 64'h1, 0, 0, 64'h0, 0, 0);
        xfer(0, "sc300", 1, 8'hFF, 32'h300, 64'h2, 0, 1, 64'h0, 0, 0);
        xfer(0, "rd300", 0, 8'hFF, 32'h300, 64'h0, 0, 0, 64'h1, 0, 0);

        // Out-of-window access is never answered.
        cyc[0] = 1'b1; stb[0] = 1'b1; sel[0] = 8'hFF; adr[0] = 32'h0000_8000;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack[0] || err[0]) acks++;
        end
        check("window_no_ack", 64'(acks), 64'h0);
        idle_bus(0);
        repeat (2) @(negedge clk);

`ifdef ANY1_BUSRSP_ERR_EN
        xfer(0, "rd_sel0_err", 0, 8'h00, 32'h100, 64'h0, 0, 0, 64'h0, 0, 1);
`endif

        // Abort in the second wait cycle with three wait states.
        xfer(1, "pre400", 1, 8'hFF, 32'h400, 64'h0, 0, 0, 64'h0, 0, 0);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 8'hFF;
        adr[1] = 32'h400; din[1] = 64'hBAD0_BAD0_BAD0_BAD0;
        repeat (2) @(negedge clk);
        idle_bus(1);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack[1] || err[1]) acks++;
        end
        check("abort_no_ack", 64'(acks), 64'h0);
        xfer(1, "rd400_abort", 0, 8'hFF, 32'h400, 64'h0, 0, 0, 64'h0, 0, 0);

        // Reset while waiting: outputs clear at once, the write never lands.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 8'hFF;
        adr[1] = 32'h400; din[1] = 64'h77;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_wait", 1);
        idle_bus(1);
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack[1] || err[1]) acks++;
        end
        check("rst_wait_no_ack", 64'(acks), 64'h0);
        xfer(1, "rd400_rst", 0, 8'hFF, 32'h400, 64'h0, 0, 0, 64'h0, 0, 0);

        // Reset during an ack cycle also drops the reservation.
        xfer(0, "lr200_again", 0, 8'hFF, 32'h200, 64'h0, 1, 0, 64'h5, 0, 0);
        cyc[0] = 1'b1; stb[0] = 1'b1; sel[0] = 8'hFF; adr[0] = 32'h100;
        got = 1'b0;
        n = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = ack[0];
        end
        check_bit("rst_ack_seen", got, 1'b1);
        check("rst_ack_dat_before", dout[0], 64'hDEADBEEF_01234567);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_ack", 0);
        idle_bus(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(0, "sc200_after_rst", 1, 8'hFF, 32'h200, 64'h7, 0, 1, 64'h0, 0, 0);
        xfer(0, "rd200_after_rst", 0, 8'hFF, 32'h200, 64'h0, 0, 0, 64'h5, 0, 0);

        check("sb_empty", 64'(sb.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
